// File: rtl/vmu_req_sched.sv
// Vector memory unit request scheduler: keeps dispatched engine ids in program
// order and arbitrates the shared cache port in favour of the queue head.
module vmu_req_sched #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               valid_in,
  input  logic                               is_load,
  input  logic                               is_store,
  input  logic                               is_toepl,
  input  logic                               is_reconf,
  output logic                               ready_o,
  input  logic [2:0]                         engine_ready_i,
  output logic [2:0]                         push_o,
  input  logic [2:0]                         busy_i,
  input  logic [2:0]                         req_i,
  output logic [2:0]                         grant_o,
  input  logic                               cache_ready_i,
  output logic                               mem_req_valid_o,
  input  logic                               mem_resp_valid_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   ld_outstanding_o,
  output logic [2:0]                         head_o,
  output logic                               sched_idle_o,
  output logic                               illegal_o,
  output logic                               resp_err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [2:0]    q_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic [CW-1:0] ld_cnt;
  logic          head_started;

  logic [2:0] cls, head, grant;
  logic       empty, full, one_class, malformed, accept_norm, accept_reconf;
  logic       head_busy, pop, push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    cls           = {is_toepl, is_store, is_load};
    empty         = (occ == '0);
    full          = (occ == FULL_OCC);
    head          = empty ? 3'b000 : q_mem[rd_ptr];
    one_class     = (cls == 3'b001) || (cls == 3'b010) || (cls == 3'b100);
    malformed     = !rst && valid_in && !is_reconf && !one_class;
    accept_norm   = !rst && valid_in && !is_reconf && one_class &&
                    (|(cls & engine_ready_i)) && !full;
    accept_reconf = !rst && valid_in && is_reconf && (&engine_ready_i) &&
                    empty && (ld_cnt == '0);
    push          = accept_norm;
    head_busy     = |(head & busy_i);
    pop           = !empty && head_started && !head_busy;
  end

  // Only the head may use the cache; stores wait for all loads to drain.
  always_comb begin
    grant = 3'b000;
    if (!rst && !empty && cache_ready_i && (|(head & req_i))) begin
      case (head)
        3'b001:  if (ld_cnt < MAX_CNT) grant = 3'b001;
        3'b010:  if (ld_cnt == '0) grant = 3'b010;
        3'b100:  grant = 3'b100;
        default: grant = 3'b000;
      endcase
    end
  end

  always_comb begin
    ready_o          = accept_norm || accept_reconf || malformed;
    push_o           = accept_reconf ? 3'b111 : (accept_norm ? cls : 3'b000);
    illegal_o        = malformed;
    grant_o          = grant;
    mem_req_valid_o  = |grant;
    resp_err_o       = !rst && mem_resp_valid_i && (ld_cnt == '0);
    ld_outstanding_o = ld_cnt;
    head_o           = rst ? 3'b000 : head;
    sched_idle_o     = rst || (empty && (ld_cnt == '0) && !(|busy_i) && !valid_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      ld_cnt       <= '0;
      head_started <= 1'b0;
    end else begin
      if (push) begin
        q_mem[wr_ptr] <= cls;
        wr_ptr        <= next_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= next_ptr(rd_ptr);

      if (push && !pop)      occ <= occ + OW'(1);
      else if (!push && pop) occ <= occ - OW'(1);

      // The started flag stops a head whose engine has not yet picked it up
      // from being popped just because busy is still low.
      if (pop)                                               head_started <= 1'b0;
      else if (!empty && (head_busy || (|(grant & head))))   head_started <= 1'b1;

      if (grant[0] && !mem_resp_valid_i)
        ld_cnt <= ld_cnt + CW'(1);
      else if (!grant[0] && mem_resp_valid_i && (ld_cnt != '0))
        ld_cnt <= ld_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_vmu_req_sched.sv
// Self-checking bench for vmu_req_sched: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_vmu_req_sched;

  localparam int DEPTH = 4;
  localparam int MAXO  = 8;
  localparam int CW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in, is_load, is_store, is_toepl, is_reconf;
  logic          ready_o;
  logic [2:0]    engine_ready_i, push_o, busy_i, req_i, grant_o, head_o;
  logic          cache_ready_i, mem_req_valid_o, mem_resp_valid_i;
  logic [CW-1:0] ld_outstanding_o;
  logic          sched_idle_o, illegal_o, resp_err_o;

  always #5 clk = ~clk;

  vmu_req_sched #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .is_load(is_load),
    .is_store(is_store), .is_toepl(is_toepl), .is_reconf(is_reconf),
    .ready_o(ready_o), .engine_ready_i(engine_ready_i), .push_o(push_o),
    .busy_i(busy_i), .req_i(req_i), .grant_o(grant_o),
    .cache_ready_i(cache_ready_i), .mem_req_valid_o(mem_req_valid_o),
    .mem_resp_valid_i(mem_resp_valid_i), .ld_outstanding_o(ld_outstanding_o),
    .head_o(head_o), .sched_idle_o(sched_idle_o), .illegal_o(illegal_o),
    .resp_err_o(resp_err_o)
  );

  typedef struct packed {
    logic valid, ld, st, tp, rc;
    logic [2:0] er, busy, req;
    logic cache, resp;
  } in_t;

  typedef struct packed {
    logic ready; logic [2:0] push; logic ill; logic [2:0] grant;
    logic err; logic [2:0] head; logic [CW-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic ready; logic [2:0] push; logic ill; logic [2:0] grant; logic memreq;
    logic err; logic [2:0] head; logic [CW-1:0] cnt; logic idle;
  } full_t;

  typedef struct packed { in_t stim; exp_t exp; } vec_t;

  int    vectors = 0;
  int    miscompares = 0;
  vec_t  tbl[$];
  in_t   cur;
  full_t act_full, mod_full;
  exp_t  act_e;

  // Reference model state: engine indices in program order.
  int q[$];
  int cnt;
  bit started;

  function automatic in_t mk_in(input logic v, ld, st, tp, rc, input logic [2:0] er, busy, req,
                                input logic cache, resp);
    in_t s;
    s = '{valid: v, ld: ld, st: st, tp: tp, rc: rc, er: er, busy: busy, req: req,
          cache: cache, resp: resp};
    return s;
  endfunction

  function automatic exp_t mk_exp(input logic r, input logic [2:0] p, input logic il,
                                  input logic [2:0] g, input logic e, input logic [2:0] h,
                                  input int c);
    exp_t x;
    x = '{ready: r, push: p, ill: il, grant: g, err: e, head: h, cnt: CW'(c)};
    return x;
  endfunction

  function automatic full_t model_out(input in_t s);
    full_t o;
    int n, e, h;
    o = '0;
    n = int'(s.ld) + int'(s.st) + int'(s.tp);
    e = s.ld ? 0 : (s.st ? 1 : 2);
    h = (q.size() > 0) ? q[0] : -1;
    if (s.valid) begin
      if (s.rc) begin
        if (s.er == 3'b111 && q.size() == 0 && cnt == 0) begin
          o.ready = 1'b1; o.push = 3'b111;
        end
      end else if (n != 1) begin
        o.ready = 1'b1; o.ill = 1'b1;
      end else if (s.er[e] && q.size() < DEPTH) begin
        o.ready = 1'b1; o.push = 3'(1 << e);
      end
    end
    if (h >= 0 && s.req[h] && s.cache) begin
      if ((h == 0 && cnt < MAXO) || (h == 1 && cnt == 0) || h == 2) o.grant = 3'(1 << h);
    end
    o.memreq = (o.grant != 3'b000);
    o.err    = s.resp && cnt == 0;
    o.head   = (h >= 0) ? 3'(1 << h) : 3'b000;
    o.cnt    = CW'(cnt);
    o.idle   = q.size() == 0 && cnt == 0 && s.busy == 3'b000 && !s.valid;
    return o;
  endfunction

  function automatic void model_update(input in_t s);
    full_t o;
    int h;
    bit pop;
    o   = model_out(s);
    h   = (q.size() > 0) ? q[0] : -1;
    pop = h >= 0 && started && !s.busy[h];
    if (pop) started = 0;
    else if (h >= 0 && (s.busy[h] || o.grant[h])) started = 1;
    if (pop) void'(q.pop_front());
    if (o.push != 3'b000 && o.push != 3'b111) q.push_back(o.push[0] ? 0 : (o.push[1] ? 1 : 2));
    if (o.grant[0] && !s.resp) cnt++;
    else if (!o.grant[0] && s.resp && cnt > 0) cnt--;
  endfunction

  function automatic in_t rand_in();
    in_t s;
    int r;
    s = '0;
    s.valid = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 9);
    case (r)
      0: begin s.ld = 1; s.st = 1; end
      1: ;
      2, 3, 4: s.ld = 1;
      5, 6: s.st = 1;
      default: s.tp = 1;
    endcase
    s.rc = ($urandom_range(0, 19) == 0);
    for (int b = 0; b < 3; b++) begin
      s.er[b]   = ($urandom_range(0, 4) != 0);
      s.busy[b] = ($urandom_range(0, 9) < 3);
      s.req[b]  = ($urandom_range(0, 9) < 6);
    end
    s.cache = ($urandom_range(0, 9) < 7);
    s.resp  = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  task automatic applyStimulus(input in_t s);
    cur              = s;
    valid_in         = s.valid;
    is_load          = s.ld;
    is_store         = s.st;
    is_toepl         = s.tp;
    is_reconf        = s.rc;
    engine_ready_i   = s.er;
    busy_i           = s.busy;
    req_i            = s.req;
    cache_ready_i    = s.cache;
    mem_resp_valid_i = s.resp;
    #4;
    act_full = '{ready: ready_o, push: push_o, ill: illegal_o, grant: grant_o,
                 memreq: mem_req_valid_o, err: resp_err_o, head: head_o,
                 cnt: ld_outstanding_o, idle: sched_idle_o};
    act_e    = '{ready: ready_o, push: push_o, ill: illegal_o, grant: grant_o,
                 err: resp_err_o, head: head_o, cnt: ld_outstanding_o};
    mod_full = model_out(s);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    model_update(cur);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus('0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    cnt = 0;
    started = 0;
  endtask

  localparam in_t IDLE = '{valid: 0, ld: 0, st: 0, tp: 0, rc: 0, er: 3'b111, busy: 0, req: 0,
                          cache: 0, resp: 0};

  initial begin
    int ngr;

    // Directed table: load then store, illegal dispatch, reconf, toeplitz.
    tbl.push_back('{mk_in(1,1,0,0,0,7,0,0,0,0), mk_exp(1,1,0,0,0,0,0)});
    tbl.push_back('{mk_in(1,0,1,0,0,7,0,1,1,0), mk_exp(1,2,0,1,0,1,0)});
    tbl.push_back('{mk_in(1,1,1,0,0,7,1,1,1,0), mk_exp(1,0,1,1,0,1,1)});
    tbl.push_back('{mk_in(0,0,0,0,0,7,0,2,1,1), mk_exp(0,0,0,0,0,1,2)});
    tbl.push_back('{mk_in(0,0,0,0,0,7,0,2,1,0), mk_exp(0,0,0,0,0,2,1)});
    tbl.push_back('{mk_in(0,0,0,0,0,7,0,2,1,1), mk_exp(0,0,0,0,0,2,1)});
    tbl.push_back('{mk_in(0,0,0,0,0,7,0,2,1,0), mk_exp(0,0,0,2,0,2,0)});
    tbl.push_back('{mk_in(0,0,0,0,0,7,2,0,0,0), mk_exp(0,0,0,0,0,2,0)});
    tbl.push_back('{mk_in(0,0,0,0,0,7,0,0,0,0), mk_exp(0,0,0,0,0,2,0)});
    tbl.push_back('{mk_in(0,0,0,0,0,7,0,0,0,1), mk_exp(0,0,0,0,1,0,0)});
    tbl.push_back('{mk_in(1,0,0,0,1,7,0,0,0,0), mk_exp(1,7,0,0,0,0,0)});
    tbl.push_back('{mk_in(1,0,0,1,0,3,0,0,0,0), mk_exp(0,0,0,0,0,0,0)});
    tbl.push_back('{mk_in(1,0,0,1,0,4,0,0,0,0), mk_exp(1,4,0,0,0,0,0)});
    tbl.push_back('{mk_in(0,0,0,0,0,7,0,4,0,0), mk_exp(0,0,0,0,0,4,0)});
    tbl.push_back('{mk_in(0,0,0,0,0,7,0,4,1,0), mk_exp(0,0,0,4,0,4,0)});

    doReset();
    checkOutput("reset_idle", 32'(sched_idle_o), 32'd1);
    checkOutput("reset_head", 32'(head_o), 32'd0);
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].stim);
      checkOutput($sformatf("vec[%0d]", i), 32'(act_e), 32'(tbl[i].exp));
      tick();
    end

    // Credit limit: eight load grants then a stall until a response returns.
    doReset();
    applyStimulus(mk_in(1,1,0,0,0,7,0,0,0,0)); tick();
    ngr = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(mk_in(0,0,0,0,0,7,1,1,1,0));
      if (grant_o == 3'b001) ngr++;
      tick();
    end
    checkOutput("credit_grants", 32'(ngr), 32'd8);
    applyStimulus(mk_in(0,0,0,0,0,7,1,1,1,0));
    checkOutput("credit_cnt", 32'(ld_outstanding_o), 32'd8);
    checkOutput("credit_hold", 32'(grant_o), 32'd0);
    tick();
    applyStimulus(mk_in(0,0,0,0,0,7,1,1,1,1));
    checkOutput("credit_resp_cycle", 32'(grant_o), 32'd0);
    tick();
    applyStimulus(mk_in(0,0,0,0,0,7,1,1,1,0));
    checkOutput("credit_resume", 32'(grant_o), 32'd1);
    tick();

    // Full queue: a same-cycle pop does not make room.
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk_in(1,1,0,0,0,7,1,0,0,0));
      checkOutput($sformatf("full_push[%0d]", i), 32'(ready_o), 32'd1);
      tick();
    end
    applyStimulus(mk_in(1,1,0,0,0,7,1,0,0,0));
    checkOutput("full_refuse", 32'(ready_o), 32'd0);
    tick();
    applyStimulus(mk_in(1,1,0,0,0,7,0,0,0,0));
    checkOutput("full_pop_refuse", 32'(ready_o), 32'd0);
    tick();
    applyStimulus(mk_in(1,1,0,0,0,7,1,0,0,0));
    checkOutput("full_accept", 32'(ready_o), 32'd1);
    tick();

    // Reconf waits for an empty queue.
    doReset();
    applyStimulus(mk_in(1,1,0,0,0,7,0,0,0,0)); tick();
    applyStimulus(mk_in(1,0,0,0,1,7,1,0,0,0));
    checkOutput("reconf_queued_ready", 32'(ready_o), 32'd0);
    checkOutput("reconf_queued_push", 32'(push_o), 32'd0);
    tick();
    applyStimulus(mk_in(1,0,0,0,1,7,0,0,0,0));
    checkOutput("reconf_pop_ready", 32'(ready_o), 32'd0);
    tick();
    applyStimulus(mk_in(1,0,0,0,1,7,0,0,0,0));
    checkOutput("reconf_accept", 32'(push_o), 32'd7);
    tick();
    applyStimulus(IDLE);
    checkOutput("reconf_no_entry", 32'(head_o), 32'd0);
    checkOutput("reconf_idle", 32'(sched_idle_o), 32'd1);
    tick();

    // Reset mid-operation with three entries and five loads in flight.
    doReset();
    applyStimulus(mk_in(1,1,0,0,0,7,0,0,0,0)); tick();
    applyStimulus(mk_in(1,0,1,0,0,7,1,1,1,0)); tick();
    applyStimulus(mk_in(1,0,0,1,0,7,1,1,1,0)); tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk_in(0,0,0,0,0,7,1,1,1,0)); tick();
    end
    applyStimulus(mk_in(0,0,0,0,0,7,1,0,0,0));
    checkOutput("pre_reset_cnt", 32'(ld_outstanding_o), 32'd5);
    checkOutput("pre_reset_head", 32'(head_o), 32'd1);
    rst = 1'b1;
    applyStimulus(mk_in(1,1,0,0,0,7,1,1,1,0));
    checkOutput("in_reset_ready", 32'(ready_o), 32'd0);
    checkOutput("in_reset_grant", 32'(grant_o), 32'd0);
    checkOutput("in_reset_push", 32'(push_o), 32'd0);
    checkOutput("in_reset_idle", 32'(sched_idle_o), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); cnt = 0; started = 0;
    applyStimulus(mk_in(0,0,0,0,0,7,0,0,0,0));
    checkOutput("post_reset_head", 32'(head_o), 32'd0);
    checkOutput("post_reset_cnt", 32'(ld_outstanding_o), 32'd0);
    checkOutput("post_reset_idle", 32'(sched_idle_o), 32'd1);
    tick();

    // Randomized traffic against the reference model.
    doReset();
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(rand_in());
      checkOutput($sformatf("rand[%0d]", n), 32'(act_full), 32'(mod_full));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vmu_req_sched.md
VMU_REQ_SCHED -- requirements
Module: vmu_req_sched

Interface
REQ-001 The parameters SHALL be (name, default, meaning):
- DEPTH, 4: program-order queue entries.
- MAX_OUTSTANDING, 8: maximum in-flight load requests.
REQ-002 The ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the single clock; all state updates on its rising edge.
- rst, in, 1: reset, synchronous and active-high.
- valid_in, in, 1: dispatch valid.
- is_load / is_store / is_toepl / is_reconf, in, 1 each: instruction class.
- ready_o, out, 1: dispatch accepted this cycle.
- engine_ready_i, in, 3: per-engine input ready, bit0 = load, bit1 = store, bit2 = toeplitz.
- push_o, out, 3: per-engine push strobe.
- busy_i, in, 3: per-engine busy.
- req_i, in, 3: per-engine cache request.
- grant_o, out, 3: one-hot cache grant; the parent muxes the request payload with it.
- cache_ready_i, in, 1: cache accepts a request.
- mem_req_valid_o, out, 1: request issued to the cache.
- mem_resp_valid_i, in, 1: one load response returned.
- ld_outstanding_o, out, $clog2(MAX_OUTSTANDING)+1: in-flight load count.
- head_o, out, 3: one-hot id of the queue head; 0 when the queue is empty.
- sched_idle_o, out, 1: scheduler and all engines idle.
- illegal_o, out, 1: 1-cycle pulse on a malformed dispatch.
- resp_err_o, out, 1: 1-cycle pulse on a response received with count 0.

Function
REQ-003 The block SHALL keep a DEPTH-entry circular FIFO of one-hot engine ids in dispatch order; pointers wrap modulo DEPTH.
REQ-004 A non-reconf dispatch SHALL be accepted when all of the following hold, and acceptance SHALL push the id and assert the matching push_o bit in the same cycle:
- valid_in is high;
- exactly one of is_load, is_store, is_toepl is high;
- the target engine's engine_ready_i bit is high;
- the queue is not full.
REQ-005 Fullness SHALL be judged on registered occupancy; a same-cycle pop SHALL NOT make room for a push.
REQ-006 A reconf dispatch SHALL be accepted only when all engine_ready_i bits are high, the queue is empty and ld_outstanding_o==0.
- Acceptance asserts push_o=3'b111.
- No queue entry is created.
- is_reconf overrides the class bits.
REQ-007 A malformed dispatch (valid_in high, no reconf, zero or more than one class bit) SHALL assert ready_o and illegal_o, drop the instruction and assert no push.
REQ-008 ready_o SHALL be combinational and equal to the accept/drop condition of REQ-004, REQ-006 and REQ-007.
REQ-009 grant_o[k] SHALL be combinational and high iff all of the following hold:
- the queue is non-empty, head==k and req_i[k] is high;
- cache_ready_i is high;
- for load: ld_outstanding_o < MAX_OUTSTANDING;
- for store: ld_outstanding_o==0.
REQ-010 At most one grant_o bit SHALL be high per cycle; mem_req_valid_o SHALL equal |grant_o.
REQ-011 The load counter SHALL update as follows:
- +1 on a load grant;
- -1 on mem_resp_valid_i;
- both in the same cycle: unchanged;
- a response while the count is 0: count stays 0 and resp_err_o pulses.
REQ-012 A head_started flag SHALL be set when busy_i[head] or grant_o[head] is seen high, and cleared on pop.
REQ-013 The head SHALL pop in the cycle where head_started==1 and busy_i[head]==0; the next entry's grants are eligible from the following cycle.
REQ-014 A push to an empty queue SHALL become head next cycle with head_started=0, so a not-yet-busy engine is never popped early.
REQ-015 sched_idle_o SHALL equal: queue empty & ld_outstanding_o==0 & ~|busy_i & ~valid_in.

Reset
REQ-016 While rst is high the block SHALL:
- empty the queue and zero both pointers and the load counter;
- clear head_started;
- drive grant_o, push_o, illegal_o, resp_err_o and head_o to 0 and sched_idle_o to 1.
REQ-017 Reset mid-operation SHALL discard all queue entries and counts without issuing further grants.
REQ-018 ready_o SHALL be 0 during reset.

Verification
REQ-019 Load then store: dispatch load, then store; load engine busy 3 cycles with 2 grants -> ld_outstanding_o reaches 2; the store is not granted until the load pops and both responses return; then grant_o=3'b010.
REQ-020 Credit limit: MAX_OUTSTANDING=8, load req_i held high with no responses -> exactly 8 grants; grant_o stays 0; it resumes 1 cycle after the first response.
REQ-021 Full queue: 4 dispatches with the head engine stalled busy -> 5th has ready_o=0; with the head popping in the same cycle the 5th is still refused and is accepted the next cycle.
REQ-022 Reconf: reconf with 1 queued entry -> ready_o=0; after the queue empties and the count is 0 -> push_o=3'b111 for 1 cycle, with no queue entry.
REQ-023 Errors: is_load and is_store both high -> illegal_o=1, ready_o=1, push_o=0; mem_resp_valid_i with count 0 -> resp_err_o=1 and the count stays 0.
REQ-024 Reset with 3 entries queued and count 5 -> next cycle head_o=0, ld_outstanding_o=0, sched_idle_o=1.
